// File: rtl/candidate_checker_pkg.sv
// Shared definitions for the factoring datapath: default operand width and
// the checker FSM encoding, used by both the sieve and the candidate checker.
package candidate_checker_pkg;

  localparam int DEFAULT_N_DIGIT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

endpackage

// File: rtl/candidate_checker_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor when it fits.
module restoring_div_step #(
  parameter int HALF = 32
) (
  input  logic [HALF:0]   rem_in,
  input  logic            bit_in,
  input  logic [HALF-1:0] divisor,
  output logic [HALF:0]   rem_out,
  output logic            q_bit
);

  logic [HALF+1:0] shifted;
  logic [HALF+1:0] divisor_ext;

  assign shifted     = {rem_in, bit_in};
  assign divisor_ext = {2'b00, divisor};

  // The incoming remainder is always below the divisor, so the shifted value
  // fits in HALF+1 bits and the truncations below never lose information.
  always_comb begin
    rem_out = shifted[HALF:0];
    q_bit   = 1'b0;
    if (shifted >= divisor_ext) begin
      rem_out = (HALF+1)'(shifted - divisor_ext);
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/candidate_checker.sv
// Checks one sieve candidate against N by bit-serial restoring division,
// reporting quotient, remainder and whether the candidate is a real factor.
module candidate_checker
  import candidate_checker_pkg::*;
#(
  parameter int max_N_digit = DEFAULT_N_DIGIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [max_N_digit-1:0]     N,
  input  logic [max_N_digit/2-1:0]   cand,
  output logic                       ready,
  output logic                       done,
  output logic                       is_factor,
  output logic                       invalid,
  output logic [max_N_digit-1:0]     quotient,
  output logic [max_N_digit/2-1:0]   remainder
);

  localparam int HALF  = max_N_digit / 2;
  localparam int CNT_W = $clog2(max_N_digit);

  chk_state_t             state;
  logic [max_N_digit-1:0] work_reg;
  logic [HALF-1:0]        divisor;
  logic [HALF:0]          part_rem;
  logic [CNT_W-1:0]       step_count;

  logic [HALF:0]          step_rem;
  logic                   step_qbit;
  logic [max_N_digit-1:0] q_next;

  // work_reg feeds dividend bits out of its MSB while quotient bits enter at
  // the LSB, so after the last step it holds the full quotient.
  assign q_next = {work_reg[max_N_digit-2:0], step_qbit};

  restoring_div_step #(
    .HALF(HALF)
  ) u_step (
    .rem_in (part_rem),
    .bit_in (work_reg[max_N_digit-1]),
    .divisor(divisor),
    .rem_out(step_rem),
    .q_bit  (step_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      work_reg   <= '0;
      divisor    <= '0;
      part_rem   <= '0;
      step_count <= '0;
      ready      <= 1'b1;
      done       <= 1'b0;
      is_factor  <= 1'b0;
      invalid    <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ready <= 1'b0;
            if (~|cand[HALF-1:1]) begin
              state     <= DONE;
              done      <= 1'b1;
              invalid   <= 1'b1;
              is_factor <= 1'b0;
              quotient  <= '0;
              remainder <= '0;
            end else begin
              state      <= DIV;
              work_reg   <= N;
              divisor    <= cand;
              part_rem   <= '0;
              step_count <= CNT_W'(max_N_digit - 1);
            end
          end
        end

        DIV: begin
          work_reg   <= q_next;
          part_rem   <= step_rem;
          step_count <= step_count - 1'b1;
          if (step_count == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            invalid   <= 1'b0;
            quotient  <= q_next;
            remainder <= step_rem[HALF-1:0];
            // A quotient of 1 means cand equals N, which is not a useful factor.
            is_factor <= (step_rem == '0) && (|q_next[max_N_digit-1:1]);
          end
        end

        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
